// File: rtl/microseq_if.sv
// microseq_if: control-path bundle between the microsequencer and the
// datapath / instruction register.
//   master : sequencer side (consumes opcode/ready/resume, drives state,
//            cycle, halted, illegal, instr_done)
//   slave  : datapath / environment side (the mirror image)
interface microseq_if #(
  parameter int OPCODE_W = 4,
  parameter int STATE_W  = 4,
  parameter int CYC_W    = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                ready;
  logic                resume;
  logic [STATE_W-1:0]  state;
  logic [CYC_W-1:0]    cycle;
  logic                halted;
  logic                illegal;
  logic                instr_done;

  modport master (
    input  opcode, ready, resume,
    output state, cycle, halted, illegal, instr_done
  );

  modport slave (
    output opcode, ready, resume,
    input  state, cycle, halted, illegal, instr_done
  );
endinterface

// File: rtl/microseq.sv
// microseq: microsequencer for the 8-bit computer's control path.
// Keeps the instruction cycle counter, latches the opcode at the end of
// fetch and decodes one control state per cycle. Supports variable-length
// instructions (early return to fetch on STATE_NEXT), a ready stall, a
// sticky halt with resume, illegal-opcode flagging and a retire strobe.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : microseq_if.master (opcode, ready, resume in;
//           state, cycle, halted, illegal, instr_done out)
module microseq #(
  parameter int OPCODE_W = 4,
  parameter int STATE_W  = 4,
  parameter int CYC_W    = 3
) (
  input  logic       clk,
  input  logic       reset,
  microseq_if.master bus
);

  localparam logic [STATE_W-1:0] STATE_FETCH_PC         = STATE_W'(0);
  localparam logic [STATE_W-1:0] STATE_FETCH_INST       = STATE_W'(1);
  localparam logic [STATE_W-1:0] STATE_FETCH_ARG        = STATE_W'(2);
  localparam logic [STATE_W-1:0] STATE_LOAD_Z           = STATE_W'(3);
  localparam logic [STATE_W-1:0] STATE_RAM_A            = STATE_W'(4);
  localparam logic [STATE_W-1:0] STATE_RAM_B            = STATE_W'(5);
  localparam logic [STATE_W-1:0] STATE_STORE_A          = STATE_W'(6);
  localparam logic [STATE_W-1:0] STATE_ADD              = STATE_W'(7);
  localparam logic [STATE_W-1:0] STATE_SUB              = STATE_W'(8);
  localparam logic [STATE_W-1:0] STATE_OUT_A            = STATE_W'(9);
  localparam logic [STATE_W-1:0] STATE_JUMP             = STATE_W'(10);
  localparam logic [STATE_W-1:0] STATE_JUMP_IF_ZERO     = STATE_W'(11);
  localparam logic [STATE_W-1:0] STATE_JUMP_IF_NOT_ZERO = STATE_W'(12);
  localparam logic [STATE_W-1:0] STATE_HALT             = STATE_W'(13);
  localparam logic [STATE_W-1:0] STATE_NEXT             = STATE_W'(14);

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_OUT = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JEZ = 4'd6;
  localparam logic [3:0] OP_JNZ = 4'd7;
  localparam logic [3:0] OP_HLT = 4'd8;

  logic [CYC_W-1:0]    cycle_q;
  logic [OPCODE_W-1:0] op_q;
  logic                halted_q;
  logic                illegal_q;
  logic [STATE_W-1:0]  state_c;

  // Legal opcodes have nothing set above bit 3 and a defined low nibble.
  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return ((op >> 4) == '0) && (op[3:0] <= OP_HLT);
  endfunction

  // Anything not explicitly listed falls through to STATE_NEXT, which is
  // what lets the sequencer recover from undefined (cycle, opcode) pairs.
  function automatic logic [STATE_W-1:0] decode(input logic [CYC_W-1:0]    c,
                                                input logic [OPCODE_W-1:0] op);
    logic [STATE_W-1:0] s;
    int unsigned        ci;
    logic [3:0]         o;
    s  = STATE_NEXT;
    ci = 32'(c);
    o  = op[3:0];
    if (ci == 0) begin
      s = STATE_FETCH_PC;
    end else if (ci == 1) begin
      s = STATE_FETCH_INST;
    end else if (is_legal(op)) begin
      case (o)
        OP_HLT: if (ci == 2) s = STATE_HALT;
        OP_OUT: if (ci == 2) s = STATE_OUT_A;
        OP_JMP, OP_JEZ, OP_JNZ: begin
          if (ci == 2) s = STATE_FETCH_PC;
          else if (ci == 3)
            s = (o == OP_JMP) ? STATE_JUMP :
                (o == OP_JEZ) ? STATE_JUMP_IF_ZERO : STATE_JUMP_IF_NOT_ZERO;
        end
        OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
          if (ci == 2) s = STATE_FETCH_PC;
          else if (ci == 3) s = STATE_FETCH_ARG;
          else if (ci == 4) s = STATE_LOAD_Z;
          else if (ci == 5)
            s = (o == OP_LDA) ? STATE_RAM_A :
                (o == OP_STA) ? STATE_STORE_A : STATE_RAM_B;
          else if (ci == 6 && (o == OP_ADD || o == OP_SUB))
            s = (o == OP_ADD) ? STATE_ADD : STATE_SUB;
        end
        default: s = STATE_NEXT;
      endcase
    end
    return s;
  endfunction

  assign state_c = decode(cycle_q, op_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      op_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (halted_q) begin
        // ready is ignored while halted; only resume moves us on
        if (bus.resume) begin
          halted_q <= 1'b0;
          cycle_q  <= '0;
        end
      end else if (bus.ready) begin
        // Entering halt keeps cycle at 2 so state keeps decoding as HALT.
        if (state_c == STATE_HALT)      halted_q <= 1'b1;
        else if (state_c == STATE_NEXT) cycle_q  <= '0;
        else                            cycle_q  <= cycle_q + CYC_W'(1);
        if (cycle_q == CYC_W'(1)) op_q <= bus.opcode;
        if (cycle_q == CYC_W'(2) && !is_legal(op_q)) illegal_q <= 1'b1;
      end
    end
  end

  assign bus.state      = state_c;
  assign bus.cycle      = cycle_q;
  assign bus.halted     = halted_q;
  assign bus.illegal    = illegal_q;
  assign bus.instr_done = (state_c == STATE_NEXT) && bus.ready;

endmodule

// File: tb/tb_microseq.sv
// tb_microseq: directed, table-driven bench for microseq. Each record is one
// clock cycle: the inputs held during that cycle and the outputs expected
// in it. A second instance with a 6-bit opcode covers the upper-bit check.
module tb_microseq;

  localparam logic [3:0] S_FETCH_PC = 4'd0;
  localparam logic [3:0] S_FETCH_INST = 4'd1;
  localparam logic [3:0] S_FETCH_ARG = 4'd2;
  localparam logic [3:0] S_LOAD_Z = 4'd3;
  localparam logic [3:0] S_RAM_A = 4'd4;
  localparam logic [3:0] S_RAM_B = 4'd5;
  localparam logic [3:0] S_STORE_A = 4'd6;
  localparam logic [3:0] S_ADD = 4'd7;
  localparam logic [3:0] S_OUT_A = 4'd9;
  localparam logic [3:0] S_JIZ = 4'd11;
  localparam logic [3:0] S_HALT = 4'd13;
  localparam logic [3:0] S_NEXT = 4'd14;

  localparam logic [5:0] O_LDA = 6'd0;
  localparam logic [5:0] O_ADD = 6'd1;
  localparam logic [5:0] O_SUB = 6'd2;
  localparam logic [5:0] O_STA = 6'd3;
  localparam logic [5:0] O_OUT = 6'd4;
  localparam logic [5:0] O_JEZ = 6'd6;
  localparam logic [5:0] O_HLT = 6'd8;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic       res;
    logic [3:0] st;
    logic [2:0] cyc;
    logic       hlt;
    logic       ill;
    logic       done;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  microseq_if #(.OPCODE_W(4), .STATE_W(4), .CYC_W(3)) bus1 ();
  microseq_if #(.OPCODE_W(6), .STATE_W(4), .CYC_W(3)) bus2 ();

  microseq #(.OPCODE_W(4), .STATE_W(4), .CYC_W(3)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master));
  microseq #(.OPCODE_W(6), .STATE_W(4), .CYC_W(3)) dut2 (
    .clk(clk), .reset(reset2), .bus(bus2.master));

  function automatic vec_t v(string n, logic rst, logic [5:0] op, logic rdy,
                             logic res, logic [3:0] st, logic [2:0] cyc,
                             logic hlt, logic ill, logic done);
    vec_t r;
    r.name = n; r.rst = rst; r.op = op; r.rdy = rdy; r.res = res;
    r.st = st; r.cyc = cyc; r.hlt = hlt; r.ill = ill; r.done = done;
    return r;
  endfunction

  task automatic step(input vec_t x, input bit d2);
    logic [3:0] a_st;
    logic [2:0] a_cyc;
    logic       a_h, a_i, a_d;
    @(posedge clk);
    #1;
    if (!d2) begin
      reset = x.rst; bus1.opcode = x.op[3:0]; bus1.ready = x.rdy; bus1.resume = x.res;
    end else begin
      reset2 = x.rst; bus2.opcode = x.op; bus2.ready = x.rdy; bus2.resume = x.res;
    end
    @(negedge clk);
    if (!d2) begin
      a_st = bus1.state; a_cyc = bus1.cycle; a_h = bus1.halted;
      a_i = bus1.illegal; a_d = bus1.instr_done;
    end else begin
      a_st = bus2.state; a_cyc = bus2.cycle; a_h = bus2.halted;
      a_i = bus2.illegal; a_d = bus2.instr_done;
    end
    vectors++;
    if (a_st !== x.st || a_cyc !== x.cyc || a_h !== x.hlt ||
        a_i !== x.ill || a_d !== x.done) begin
      miscompares++;
      $display("FAIL %s: got state=%0d cycle=%0d halted=%b illegal=%b done=%b, want state=%0d cycle=%0d halted=%b illegal=%b done=%b",
               x.name, a_st, a_cyc, a_h, a_i, a_d, x.st, x.cyc, x.hlt, x.ill, x.done);
    end
  endtask

  initial begin
    bus1.opcode = '0; bus1.ready = 1'b1; bus1.resume = 1'b0;
    bus2.opcode = '0; bus2.ready = 1'b0; bus2.resume = 1'b0;

    //            name          rst op     rdy res  state         cyc h  i  d
    tbl.push_back(v("rst_state",  0, O_ADD, 1, 0, S_FETCH_PC,   0, 0, 0, 0));
    tbl.push_back(v("add_c1",     0, O_ADD, 1, 0, S_FETCH_INST, 1, 0, 0, 0));
    tbl.push_back(v("add_c2",     0, O_ADD, 1, 0, S_FETCH_PC,   2, 0, 0, 0));
    tbl.push_back(v("add_c3",     0, O_ADD, 1, 0, S_FETCH_ARG,  3, 0, 0, 0));
    tbl.push_back(v("add_c4",     0, O_ADD, 1, 0, S_LOAD_Z,     4, 0, 0, 0));
    tbl.push_back(v("add_c5",     0, O_ADD, 1, 0, S_RAM_B,      5, 0, 0, 0));
    tbl.push_back(v("add_c6",     0, O_ADD, 1, 0, S_ADD,        6, 0, 0, 0));
    tbl.push_back(v("add_c7",     0, O_ADD, 1, 0, S_NEXT,       7, 0, 0, 1));
    tbl.push_back(v("jez_c0",     0, O_JEZ, 1, 0, S_FETCH_PC,   0, 0, 0, 0));
    tbl.push_back(v("jez_c1",     0, O_JEZ, 1, 0, S_FETCH_INST, 1, 0, 0, 0));
    tbl.push_back(v("jez_c2",     0, O_JEZ, 1, 0, S_FETCH_PC,   2, 0, 0, 0));
    tbl.push_back(v("jez_stall0", 0, O_JEZ, 0, 0, S_JIZ,        3, 0, 0, 0));
    tbl.push_back(v("jez_stall1", 0, O_JEZ, 0, 0, S_JIZ,        3, 0, 0, 0));
    tbl.push_back(v("jez_c3",     0, O_JEZ, 1, 0, S_JIZ,        3, 0, 0, 0));
    tbl.push_back(v("jez_c4",     0, O_JEZ, 1, 0, S_NEXT,       4, 0, 0, 1));
    tbl.push_back(v("out_c0",     0, O_OUT, 1, 0, S_FETCH_PC,   0, 0, 0, 0));
    tbl.push_back(v("out_c1",     0, O_OUT, 1, 0, S_FETCH_INST, 1, 0, 0, 0));
    tbl.push_back(v("out_c2",     0, O_OUT, 1, 0, S_OUT_A,      2, 0, 0, 0));
    tbl.push_back(v("out_stall",  0, O_OUT, 0, 0, S_NEXT,       3, 0, 0, 0));
    tbl.push_back(v("out_c3",     0, O_OUT, 1, 0, S_NEXT,       3, 0, 0, 1));
    tbl.push_back(v("lda_c0",     0, O_LDA, 1, 0, S_FETCH_PC,   0, 0, 0, 0));
    tbl.push_back(v("lda_c1",     0, O_LDA, 1, 0, S_FETCH_INST, 1, 0, 0, 0));
    tbl.push_back(v("lda_c2",     0, O_LDA, 1, 0, S_FETCH_PC,   2, 0, 0, 0));
    tbl.push_back(v("lda_c3",     0, O_LDA, 1, 0, S_FETCH_ARG,  3, 0, 0, 0));
    tbl.push_back(v("lda_c4_sub", 0, O_SUB, 1, 0, S_LOAD_Z,     4, 0, 0, 0));
    tbl.push_back(v("lda_c5",     0, O_SUB, 1, 0, S_RAM_A,      5, 0, 0, 0));
    tbl.push_back(v("lda_c6",     0, O_SUB, 1, 0, S_NEXT,       6, 0, 0, 1));
    tbl.push_back(v("ill_c0",     0, 6'hF,  1, 0, S_FETCH_PC,   0, 0, 0, 0));
    tbl.push_back(v("ill_c1",     0, 6'hF,  1, 0, S_FETCH_INST, 1, 0, 0, 0));
    tbl.push_back(v("ill_c2",     0, 6'hF,  1, 0, S_NEXT,       2, 0, 0, 1));
    tbl.push_back(v("ill_pulse",  0, O_HLT, 1, 0, S_FETCH_PC,   0, 0, 1, 0));
    tbl.push_back(v("hlt_c1",     0, O_HLT, 1, 0, S_FETCH_INST, 1, 0, 0, 0));
    tbl.push_back(v("hlt_c2",     0, O_HLT, 1, 0, S_HALT,       2, 0, 0, 0));

    repeat (2) @(posedge clk);
    foreach (tbl[i]) step(tbl[i], 1'b0);

    // Halted: ready toggling is ignored for 20 cycles.
    for (int i = 0; i < 20; i++)
      step(v("halt_hold", 0, O_HLT, i[0], 0, S_HALT, 2, 1, 0, 0), 1'b0);
    step(v("resume_req",  0, O_HLT, 1, 1, S_HALT,       2, 1, 0, 0), 1'b0);
    step(v("resume_c0",   0, O_STA, 1, 1, S_FETCH_PC,   0, 0, 0, 0), 1'b0);
    step(v("resume_ign",  0, O_STA, 1, 0, S_FETCH_INST, 1, 0, 0, 0), 1'b0);

    // STA with reset asserted during cycle 5.
    step(v("sta_c2",      0, O_STA, 1, 0, S_FETCH_PC,   2, 0, 0, 0), 1'b0);
    step(v("sta_c3",      0, O_STA, 1, 0, S_FETCH_ARG,  3, 0, 0, 0), 1'b0);
    step(v("sta_c4",      0, O_STA, 1, 0, S_LOAD_Z,     4, 0, 0, 0), 1'b0);
    step(v("sta_c5_rst",  1, O_STA, 1, 0, S_STORE_A,    5, 0, 0, 0), 1'b0);
    step(v("sta_after",   0, O_STA, 1, 0, S_FETCH_PC,   0, 0, 0, 0), 1'b0);
    step(v("sta_refetch", 0, O_STA, 1, 0, S_FETCH_INST, 1, 0, 0, 0), 1'b0);

    // 6-bit opcode instance: 0x12 is undefined, 0x02 is a legal SUB.
    step(v("w6_rst",      0, 6'h12, 1, 0, S_FETCH_PC,   0, 0, 0, 0), 1'b1);
    step(v("w6_c1",       0, 6'h12, 1, 0, S_FETCH_INST, 1, 0, 0, 0), 1'b1);
    step(v("w6_ill_c2",   0, 6'h12, 1, 0, S_NEXT,       2, 0, 0, 1), 1'b1);
    step(v("w6_pulse",    0, O_SUB, 1, 0, S_FETCH_PC,   0, 0, 1, 0), 1'b1);
    step(v("w6_sub_c1",   0, O_SUB, 1, 0, S_FETCH_INST, 1, 0, 0, 0), 1'b1);
    step(v("w6_sub_c2",   0, O_SUB, 1, 0, S_FETCH_PC,   2, 0, 0, 0), 1'b1);
    step(v("w6_sub_c3",   0, O_SUB, 1, 0, S_FETCH_ARG,  3, 0, 0, 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/microseq.md
# microseq

Parametrised microsequencer for the 8-bit computer's control path. It owns the instruction cycle counter, latches the opcode at the end of instruction fetch, and issues one control state per cycle from the shared parameter include (`STATE_*`, `OP_*`). Over the fixed-length decoder it adds variable-length instructions (early return to fetch on `STATE_NEXT`), a memory-ready stall, a sticky halt with resume, illegal-opcode detection and an instruction-retired strobe. The datapath consumes `state` directly.

## Interface
- `OPCODE_W`, 4: opcode width. Bits above bit 3 must be zero for a legal opcode.
- `STATE_W`, 4: width of `state`. Must be at least 4.
- `CYC_W`, 3: cycle counter width. Must be at least 3, since the longest instruction ends in cycle 7.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input OPCODE_W: instruction-register opcode field. Sampled only at the end of cycle 1.
- `ready` input 1: memory/datapath ready. Low freezes the sequencer.
- `resume` input 1: when halted, a high level restarts at cycle 0.
- `state` output STATE_W: current control state. Combinational decode of the cycle counter and latched opcode.
- `cycle` output CYC_W: registered cycle counter.
- `halted` output 1: registered, sticky.
- `illegal` output 1: registered one-cycle pulse on an undefined opcode.
- `instr_done` output 1: combinational. High while `state==STATE_NEXT && ready`.

## Operation
- Registers: `cycle`, `op_q` (latched opcode), `halted`, `illegal`.
- Reset values: `cycle=0`, `op_q=0`, `halted=0`, `illegal=0`. Hence `state=STATE_FETCH_PC` and `instr_done=0`.
- Cycles 0 and 1 are common to every instruction: `STATE_FETCH_PC`, then `STATE_FETCH_INST`. `op_q <= opcode` on the edge leaving cycle 1.
- Sequences from cycle 2 onward, by `op_q`:
  - HLT: `STATE_HALT`.
  - OUT: `STATE_OUT_A`, then `STATE_NEXT`.
  - JMP / JEZ / JNZ: `STATE_FETCH_PC`, then `STATE_JUMP` / `STATE_JUMP_IF_ZERO` / `STATE_JUMP_IF_NOT_ZERO`, then `STATE_NEXT`.
  - LDA: `STATE_FETCH_PC`, `STATE_FETCH_ARG`, `STATE_LOAD_Z`, `STATE_RAM_A`, `STATE_NEXT`.
  - STA: as LDA, but cycle 5 is `STATE_STORE_A`, then `STATE_NEXT`.
  - ADD / SUB: `STATE_FETCH_PC`, `STATE_FETCH_ARG`, `STATE_LOAD_Z`, `STATE_RAM_B`, `STATE_ADD` / `STATE_SUB`, `STATE_NEXT`.
  - Undefined opcode, including any nonzero bit above bit 3: `STATE_NEXT` at cycle 2.
- Counter update when `ready=1` and not halted:
  - If `state==STATE_NEXT`, `cycle <= 0`.
  - Otherwise `cycle <= cycle+1`.
  - Wrap at `2^CYC_W` never occurs for legal sequences. Any undecodable (cycle, op) pair decodes to `STATE_NEXT`, so the sequencer always recovers.
- Stall: with `ready=0`, `cycle`, `op_q` and `state` hold, and `instr_done=0`. This applies in every state.
- Halt: on the edge leaving `STATE_HALT` with `ready=1`, `halted <= 1` and `cycle` holds at 2, so `state` stays `STATE_HALT`. While halted, `ready` is ignored.
- Resume: while `halted=1`, `resume=1` clears `halted` and sets `cycle <= 0` on the next edge. `resume` is ignored when not halted.
- `illegal`: pulses high for one cycle, on the cycle after cycle 2 of an undefined opcode.
- Reset priority: `reset` beats `ready`, `resume` and halt. Reset mid-instruction returns to cycle 0 on the next edge with all registers at their reset values.

## Timing
- Single clock domain, synchronous reset, no combinational path from `opcode` to `state`.
- `state` depends only on registers. `instr_done` additionally depends on `ready`.
- Instruction length in cycles, with `ready` held high: OUT 4, jumps 5, LDA 7, STA 7, ADD/SUB 8, undefined 3, HLT enters halt after 3.
- Each low cycle of `ready` adds exactly one cycle to the instruction.
- Resume latency: 1 cycle from `resume` high to `state==STATE_FETCH_PC`.

## Test plan
- Reset, then ADD (opcode=`OP_ADD`, `ready=1`) -> `state` follows FETCH_PC, FETCH_INST, FETCH_PC, FETCH_ARG, LOAD_Z, RAM_B, ADD, NEXT. `instr_done` is high only in cycle 7, and `cycle` is 0 on the 9th cycle.
- JEZ with `ready` low for 2 cycles at cycle 3 -> `STATE_JUMP_IF_ZERO` is held for 3 cycles, the instruction totals 7 cycles, and `cycle` never skips a value.
- HLT -> `halted=1` from the cycle after cycle 2 and `state` stays `STATE_HALT` for 20 cycles with `ready` toggling. A `resume` pulse then gives `STATE_FETCH_PC` and `halted=0` next cycle.
- Opcode 0xF (undefined), and with OPCODE_W=6 opcode 0x12 -> `STATE_NEXT` at cycle 2, an `illegal` pulse for exactly 1 cycle, and the next fetch at cycle 0.
- Opcode input changed to `OP_SUB` during cycle 4 of an LDA -> the sequence completes as LDA (`STATE_RAM_A` at cycle 5).
- `reset` asserted at cycle 5 of STA -> the next cycle shows `cycle=0`, `state=STATE_FETCH_PC`, `illegal=0`, `halted=0`.
